// File: rtl/m_axi_read_engine.sv
// m_axi_read_engine: AXI4-Lite single-beat read master streaming a word run to the sequencer.
module m_axi_read_engine #(
  parameter int GLOB_ADDR_WIDTH = 32,
  parameter int GLOB_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_STRIDE     = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [GLOB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]       cmd_len,
  output logic [GLOB_DATA_WIDTH-1:0] rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       rd_last,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_resp,
  output logic                       timeout,
  output logic [GLOB_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  state_t state;
  logic [CNT_WIDTH-1:0] len, issued, received, issued_n;
  logic [OW-1:0] outstanding, out_n;
  logic [TW-1:0] tcnt;
  logic ar_hs, r_hs, last_hs, issue, tmo;
  assign cmd_ready = state == IDLE;
  assign rd_data = M_AXI_RDATA;
  // Beats outside RUN are late stragglers: accept and drop them.
  assign rd_valid = state == RUN && M_AXI_RVALID;
  assign M_AXI_RREADY = state != RUN || rd_ready;
  assign rd_last = state == RUN && received == len - 1'b1;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs = rd_valid && rd_ready;
  assign last_hs = r_hs && rd_last;
  assign issued_n = issued + CNT_WIDTH'(ar_hs);
  assign out_n = outstanding + OW'(ar_hs) - OW'(r_hs);
  assign issue = issued_n < len && out_n < OW'(MAX_OUTSTANDING);
  assign tmo = TIMEOUT_CYCLES > 0 && !ar_hs && !r_hs && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      len <= '0;
      issued <= '0;
      received <= '0;
      outstanding <= '0;
      tcnt <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_resp <= 2'b00;
      timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          len <= cmd_len;
          issued <= '0;
          received <= '0;
          outstanding <= '0;
          tcnt <= '0;
          err <= 1'b0;
          err_resp <= 2'b00;
          timeout <= 1'b0;
          M_AXI_ARADDR <= cmd_addr;
          M_AXI_ARVALID <= cmd_len != '0;
          done <= cmd_len == '0;
          state <= cmd_len == '0 ? DONE : RUN;
        end
        RUN: begin
          issued <= issued_n;
          outstanding <= out_n;
          received <= received + CNT_WIDTH'(r_hs);
          tcnt <= (ar_hs || r_hs) ? '0 : tcnt + 1'b1;
          if (r_hs && M_AXI_RRESP != 2'b00) begin
            err <= 1'b1;
            if (!err) err_resp <= M_AXI_RRESP;
          end
          if (last_hs || tmo) begin
            state <= DONE;
            done <= 1'b1;
            timeout <= tmo;
            M_AXI_ARVALID <= 1'b0;
          end else if (!M_AXI_ARVALID || M_AXI_ARREADY) begin
            // ARADDR holds the last issued address, so the next one is one stride on.
            M_AXI_ARVALID <= issue;
            if (issue) M_AXI_ARADDR <= M_AXI_ARADDR + GLOB_ADDR_WIDTH'(ADDR_STRIDE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_axi_read_engine.sv
// tb_m_axi_read_engine: directed and random checks of the read engine against an AXI slave model.
module tb_m_axi_read_engine;
  localparam int AW = 32, DW = 32, CW = 8, MO = 4, STRIDE = 4, TMO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [CW-1:0] cmd_len = '0;
  logic rd_ready = 1'b1;
  logic ARREADY = 1'b0, RVALID = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic [1:0] RRESP = 2'b00;
  logic cmd_ready, rd_valid, rd_last, done, err, timeout, arvalid, rready;
  logic [DW-1:0] rd_data;
  logic [1:0] err_resp;
  logic [AW-1:0] araddr;
  logic t_cmd_ready, t_rd_valid, t_rd_last, t_done, t_err, t_timeout, t_arvalid, t_rready;
  logic [DW-1:0] t_rd_data;
  logic [1:0] t_err_resp;
  logic [AW-1:0] t_araddr;
  int total = 0, bad = 0, cyc = 0;
  logic [AW-1:0] pend[$], obs_ar[$];
  logic [DW-1:0] obs_data[$];
  logic obs_last[$];
  int ar_cyc[$];
  int last_cyc, out_cnt, max_out, arv_cnt, beat, acc_cyc, done_cyc;
  bit rvalid_en = 1'b1, r_rand = 1'b0;
  int ar_mode = 0;
  logic [1:0] resp_tab[64];

  m_axi_read_engine #(.GLOB_ADDR_WIDTH(AW), .GLOB_DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .MAX_OUTSTANDING(MO), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .done(done), .err(err), .err_resp(err_resp),
    .timeout(timeout), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(rready));

  m_axi_read_engine #(.GLOB_ADDR_WIDTH(AW), .GLOB_DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .MAX_OUTSTANDING(MO), .ADDR_STRIDE(STRIDE), .TIMEOUT_CYCLES(TMO)) dut_t (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_data(t_rd_data), .rd_valid(t_rd_valid),
    .rd_ready(rd_ready), .rd_last(t_rd_last), .done(t_done), .err(t_err), .err_resp(t_err_resp),
    .timeout(t_timeout), .M_AXI_ARADDR(t_araddr), .M_AXI_ARVALID(t_arvalid), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(t_rready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: in-order read responder plus a monitor of the dut's handshakes.
  initial begin : slave
    bit s_ar, s_r;
    logic [AW-1:0] s_addr, s_pop;
    forever begin
      @(negedge clk);
      s_ar = arvalid && ARREADY;
      s_r = RVALID && rready;
      s_addr = araddr;
      if (arvalid) arv_cnt++;
      if (s_ar) begin
        obs_ar.push_back(araddr);
        ar_cyc.push_back(cyc);
        out_cnt++;
      end
      if (rd_valid && rd_ready) begin
        obs_data.push_back(rd_data);
        obs_last.push_back(rd_last);
        out_cnt--;
        if (rd_last) last_cyc = cyc;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      @(posedge clk);
      #2;
      if (reset) begin
        pend.delete();
        RVALID = 1'b0;
        ARREADY = 1'b0;
        beat = 0;
      end else begin
        if (s_r && pend.size() > 0) begin
          s_pop = pend.pop_front();
          beat++;
          RVALID = 1'b0;
        end
        if (s_ar) pend.push_back(s_addr);
        if (!RVALID && pend.size() > 0 && rvalid_en && (!r_rand || $urandom_range(0, 1) == 1)) begin
          RVALID = 1'b1;
          RDATA = fdata(pend[0]);
          RRESP = resp_tab[6'(beat)];
        end
        ARREADY = ar_mode == 0 ? 1'b1 : ar_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic do_reset(input int arm, input bit rr, input bit ren);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ar_mode = arm;
    r_rand = rr;
    rvalid_en = ren;
    rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) resp_tab[i] = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [CW-1:0] n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = n;
    obs_ar.delete();
    obs_data.delete();
    obs_last.delete();
    ar_cyc.delete();
    out_cnt = 0;
    max_out = 0;
    arv_cnt = 0;
    beat = 0;
    last_cyc = -1;
    @(negedge clk);
    acc_cyc = cyc;
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // mode: 0 rd_ready high, 1 toggle each cycle, 2 random
  task automatic wait_done(input int budget, input int mode);
    bit tg, ok;
    tg = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (mode == 1 && !cmd_ready && !done) chk("rready_mirror", rready, rd_ready);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? tg : 1'($urandom_range(0, 1));
      tg = !tg;
    end
    chk("done_seen", ok, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
  endtask

  task automatic check_stream(input logic [AW-1:0] a, input logic [CW-1:0] n);
    bit e;
    logic [1:0] er;
    logic [AW-1:0] ea;
    e = 1'b0;
    er = 2'b00;
    for (int i = 0; i < int'(n); i++)
      if (resp_tab[6'(i)] != 2'b00 && !e) begin
        e = 1'b1;
        er = resp_tab[6'(i)];
      end
    chk("n_ar", obs_ar.size(), n);
    chk("n_rd", obs_data.size(), n);
    for (int i = 0; i < int'(n) && i < obs_ar.size(); i++) begin
      ea = a + AW'(i * STRIDE);
      chk("araddr", obs_ar[i], ea);
    end
    for (int i = 0; i < int'(n) && i < obs_data.size(); i++) begin
      ea = a + AW'(i * STRIDE);
      chk("rd_data", obs_data[i], fdata(ea));
      chk("rd_last", obs_last[i], 64'(i == int'(n) - 1));
    end
    if (n != 0) chk("done_after_last", done_cyc - last_cyc, 1);
    chk("err", err, e);
    chk("err_resp", err_resp, er);
    chk("timeout", timeout, 0);
    chk("max_outstanding", max_out <= MO, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit seen, any_done;
    logic [AW-1:0] ra;
    logic [CW-1:0] rl;
    for (int i = 0; i < 64; i++) resp_tab[i] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_resp", err_resp, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);

    // basic three-word read with everything ready
    do_reset(0, 0, 1);
    start(32'h1000, 3);
    wait_done(50, 0);
    check_stream(32'h1000, 3);
    chk("ar_b2b_1", ar_cyc.size() == 3 ? ar_cyc[1] - ar_cyc[0] : -1, 1);
    chk("ar_b2b_2", ar_cyc.size() == 3 ? ar_cyc[2] - ar_cyc[1] : -1, 1);

    // error responses on beats 2 and 3, then cleared by the next command
    do_reset(0, 0, 1);
    resp_tab[1] = 2'b10;
    resp_tab[2] = 2'b11;
    start(32'h8000, 4);
    wait_done(50, 0);
    check_stream(32'h8000, 4);
    resp_tab[1] = 2'b00;
    resp_tab[2] = 2'b00;
    start(32'h8100, 2);
    @(negedge clk);
    chk("err_cleared", err, 0);
    chk("err_resp_cleared", err_resp, 0);
    wait_done(50, 0);
    check_stream(32'h8100, 2);

    // outstanding limit while the slave withholds data
    do_reset(0, 0, 0);
    start(32'h4000, 8);
    repeat (20) @(negedge clk);
    chk("stall_n_ar", obs_ar.size(), MO);
    chk("stall_n_rd", obs_data.size(), 0);
    chk("stall_max_out", max_out, MO);
    @(posedge clk);
    #1;
    rvalid_en = 1'b1;
    wait_done(100, 0);
    check_stream(32'h4000, 8);
    chk("max_out_exact", max_out, MO);

    // timeout on the 16-cycle instance, then a late beat sunk in IDLE
    do_reset(0, 0, 0);
    start(32'h2000, 2);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (t_done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    chk("tmo_done_seen", seen, 1);
    // handshakes are logged in the cycle before their edge, hence the +1
    chk("tmo_delay", done_cyc - (ar_cyc.size() == 2 ? ar_cyc[1] : -1000), TMO + 1);
    chk("tmo_flag", t_timeout, 1);
    chk("tmo_arvalid", t_arvalid, 0);
    chk("tmo_err", t_err, 0);
    chk("no_tmo_default", timeout, 0);
    @(negedge clk);
    chk("tmo_done_pulse", t_done, 0);
    @(posedge clk);
    #1;
    rvalid_en = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = RVALID;
    end
    chk("late_rvalid", seen, 1);
    chk("late_rd_valid", t_rd_valid, 0);
    chk("late_rready", t_rready, 1);
    chk("late_cmd_ready", t_cmd_ready, 1);

    // address wrap and zero-length command
    do_reset(0, 0, 1);
    start(32'hFFFF_FFFC, 2);
    wait_done(50, 0);
    check_stream(32'hFFFF_FFFC, 2);
    start(32'h3000, 0);
    wait_done(10, 0);
    chk("len0_delay", done_cyc - acc_cyc, 1);
    chk("len0_n_ar", obs_ar.size(), 0);
    chk("len0_arvalid", arv_cnt, 0);
    chk("len0_err", err, 0);

    // rd_ready toggling every cycle
    do_reset(0, 0, 1);
    start(32'h5000, 6);
    wait_done(200, 1);
    check_stream(32'h5000, 6);

    // random addresses, lengths, responses and handshake timing
    do_reset(1, 1, 1);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 64; i++)
        resp_tab[i] = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      ra = $urandom();
      rl = CW'($urandom_range(1, 20));
      start(ra, rl);
      wait_done(800, 2);
      check_stream(ra, rl);
    end

    // asynchronous reset in the middle of a burst
    do_reset(0, 0, 1);
    resp_tab[0] = 2'b01;
    start(32'h6000, 10);
    repeat (4) @(negedge clk);
    chk("pre_rst_arvalid", arvalid, 1);
    chk("pre_rst_err", err, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_arvalid", arvalid, 0);
    chk("async_araddr", araddr, 0);
    chk("async_done", done, 0);
    chk("async_err", err, 0);
    chk("async_err_resp", err_resp, 0);
    chk("async_timeout", timeout, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    any_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_done |= done;
    end
    chk("no_done_after_reset", any_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
